// File: rtl/mac_stream_if.sv
// Streaming handshake bundle for mac_stream.
// Input side : in_valid/in_ready beats carrying in_a, in_b, in_last and in_signed.
// Output side: out_valid/out_ready result carrying out_result, out_count and out_ovf.
// Modports: master = producer of operands / consumer of results, slave = mac_stream.
interface mac_stream_if #(
    parameter int unsigned A_W   = 8,
    parameter int unsigned B_W   = 8,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic             in_last;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_result;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, in_signed, out_ready,
        input  in_ready, out_valid, out_result, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, in_signed, out_ready,
        output in_ready, out_valid, out_result, out_count, out_ovf
    );
endinterface

// File: rtl/mac_stream.sv
// Streaming multiply-accumulate: computes the dot product of a vector of (a, b) beats.
// Ports:
//   clk    - single clock, all state on rising edge
//   reset  - asynchronous active-high reset
//   clken  - global enable; low freezes all state and deasserts in_ready
//   bus    - mac_stream_if.slave: operand beats in, result/count/overflow out
// Pipeline: stage 1 registers operands, stage 2 adds the product into the accumulator.
// After the last beat the FSM drains two enabled cycles, then offers the result.
// Optional feature: define MAC_STREAM_SAT_EN to clamp the accumulator at the range limit
// of the vector's mode and report a sticky out_ovf; otherwise it wraps and out_ovf is 0.
module mac_stream #(
    parameter int unsigned A_W   = 8,
    parameter int unsigned B_W   = 8,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 8
) (
    input logic          clk,
    input logic          reset,
    input logic          clken,
    mac_stream_if.slave  bus
);

`ifdef MAC_STREAM_SAT_EN
    // Two guard bits hold any acc + product sum of either signedness without loss.
    localparam int unsigned XW = ACC_W + 2;
    localparam logic signed [XW-1:0] SMax = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [XW-1:0] SMin = {3'b111, {(ACC_W-1){1'b0}}};
    localparam logic signed [XW-1:0] UMax = {2'b00, {ACC_W{1'b1}}};
`else
    localparam int unsigned XW = ACC_W;
`endif

    typedef enum logic [1:0] {StIdle, StAcc, StDrain, StOut} state_t;

    state_t           state_q;
    logic             drain_q;
    logic             rdy_q;
    logic             mode_q;
    logic             p_valid_q;
    logic [A_W-1:0]   p_a_q;
    logic [B_W-1:0]   p_b_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] res_q;
    logic [CNT_W-1:0] res_cnt_q;

    logic             accept;
    logic signed [XW-1:0] a_ext, b_ext, prod, sum;
    logic [ACC_W-1:0] acc_sum;

    // rdy_q keeps in_ready low from reset assertion until the first clock after it.
    assign bus.in_ready   = clken & rdy_q & ((state_q == StIdle) | (state_q == StAcc));
    assign accept         = bus.in_valid & bus.in_ready;
    assign bus.out_valid  = (state_q == StOut);
    assign bus.out_result = res_q;
    assign bus.out_count  = res_cnt_q;

    // Sign- or zero-extend by the vector mode latched on the first beat.
    assign a_ext = {{(XW-A_W){mode_q & p_a_q[A_W-1]}}, p_a_q};
    assign b_ext = {{(XW-B_W){mode_q & p_b_q[B_W-1]}}, p_b_q};
    assign prod  = a_ext * b_ext;

`ifdef MAC_STREAM_SAT_EN
    logic clamp;
    logic ovf_q;
    logic res_ovf_q;

    assign sum         = $signed({{2{mode_q & acc_q[ACC_W-1]}}, acc_q}) + prod;
    assign bus.out_ovf = res_ovf_q;

    always_comb begin
        acc_sum = sum[ACC_W-1:0];
        clamp   = 1'b0;
        if (mode_q) begin
            if (sum > SMax) begin
                acc_sum = SMax[ACC_W-1:0];
                clamp   = 1'b1;
            end else if (sum < SMin) begin
                acc_sum = SMin[ACC_W-1:0];
                clamp   = 1'b1;
            end
        end else if (sum > UMax) begin
            acc_sum = UMax[ACC_W-1:0];
            clamp   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q     <= 1'b0;
            res_ovf_q <= 1'b0;
        end else if (clken) begin
            if (state_q == StIdle && accept) begin
                ovf_q <= 1'b0;
            end else if (p_valid_q) begin
                ovf_q <= ovf_q | clamp;
            end
            if (state_q == StDrain && drain_q) begin
                res_ovf_q <= ovf_q;
            end
        end
    end
`else
    // Modulo 2^ACC_W arithmetic is identical for signed and unsigned operands.
    assign sum         = $signed(acc_q) + prod;
    assign acc_sum     = sum;
    assign bus.out_ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            drain_q   <= 1'b0;
            rdy_q     <= 1'b0;
            mode_q    <= 1'b0;
            p_valid_q <= 1'b0;
            p_a_q     <= '0;
            p_b_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            res_cnt_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (clken) begin
                // Stage 1: operand registers.
                p_valid_q <= accept;
                if (accept) begin
                    p_a_q <= bus.in_a;
                    p_b_q <= bus.in_b;
                end

                // Stage 2: the pipeline is always empty in IDLE, so a first beat can
                // clear the accumulator without losing a pending product.
                if (state_q == StIdle && accept) begin
                    acc_q  <= '0;
                    mode_q <= bus.in_signed;
                    cnt_q  <= CNT_W'(1);
                end else begin
                    if (p_valid_q) begin
                        acc_q <= acc_sum;
                    end
                    if (accept && cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                case (state_q)
                    StIdle, StAcc: begin
                        if (accept) begin
                            state_q <= bus.in_last ? StDrain : StAcc;
                            drain_q <= 1'b0;
                        end
                    end
                    StDrain: begin
                        // Last product lands on the first drain edge; snapshot on the second.
                        if (drain_q) begin
                            state_q   <= StOut;
                            res_q     <= acc_q;
                            res_cnt_q <= cnt_q;
                        end else begin
                            drain_q <= 1'b1;
                        end
                    end
                    StOut: begin
                        if (bus.out_ready) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_stream.sv
// Scoreboard bench for mac_stream (A_W=B_W=8, ACC_W=20, CNT_W=8).
// Inputs change on the falling edge; the monitor samples 2 time units after it.
module tb_mac_stream;
    localparam int unsigned A_W   = 8;
    localparam int unsigned B_W   = 8;
    localparam int unsigned ACC_W = 20;
    localparam int unsigned CNT_W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic clken = 1'b1;

    mac_stream_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mac_stream #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .clken (clken),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ACC_W-1:0] res;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout, required DUT response", name);
    endtask

    // Monitor: pop and compare on every result handshake.
    always begin
        @(negedge clk);
        #2;
        if (!reset && clken && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                timeout("unexpected_result");
            end else begin
                mon_e = sb.pop_front();
                check("out_result", 32'(bus.out_result), 32'(mon_e.res));
                check("out_count", 32'(bus.out_count), 32'(mon_e.cnt));
                check("out_ovf", 32'(bus.out_ovf), 32'(mon_e.ovf));
            end
        end
    end

    // Offer one beat starting at a falling edge; returns at the falling edge after acceptance.
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last,
                        input logic sgn);
        logic took;
        took          = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_last   = last;
        bus.in_signed = sgn;
        for (int i = 0; i < 40 && !took; i++) begin
            #1;
            took = bus.in_ready;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!took) timeout("beat_accept");
    endtask

    // Falling edges waited after the last beat's acceptance edge until out_valid is seen.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.out_valid) timeout("out_valid_wait");
    endtask

    exp_t e;
    int   cyc;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.in_signed = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state.
        #1 reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_result", 32'(bus.out_result), 0);
        check("rst_out_count", 32'(bus.out_count), 0);
        check("rst_out_ovf", 32'(bus.out_ovf), 0);
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready_held", 32'(bus.in_ready), 0);
        reset = 1'b0;
        @(negedge clk);

        // Unsigned 3*4+5*6+7*8 = 98; out_valid in the third cycle after the last beat.
        e = '{res: 20'd98, cnt: 8'd3, ovf: 1'b0};
        sb.push_back(e);
        beat(8'd3, 8'd4, 1'b0, 1'b0);
        beat(8'd5, 8'd6, 1'b0, 1'b0);
        beat(8'd7, 8'd8, 1'b1, 1'b0);
        wait_out(cyc);
        check("latency_unsigned", 32'(cyc), 2);
        @(negedge clk);

        // Signed -2*3 + 4*-5 = -26.
        e = '{res: 20'hFFFE6, cnt: 8'd2, ovf: 1'b0};
        sb.push_back(e);
        beat(8'hFE, 8'd3, 1'b0, 1'b1);
        beat(8'd4, 8'hFB, 1'b1, 1'b1);
        wait_out(cyc);
        check("latency_signed", 32'(cyc), 2);
        @(negedge clk);

        // Single beat held while the consumer stalls.
        bus.out_ready = 1'b0;
        e = '{res: 20'd65025, cnt: 8'd1, ovf: 1'b0};
        sb.push_back(e);
        beat(8'd255, 8'd255, 1'b1, 1'b0);
        wait_out(cyc);
        for (int i = 0; i < 5; i++) begin
            check("hold_in_ready", 32'(bus.in_ready), 0);
            check("hold_out_valid", 32'(bus.out_valid), 1);
            check("hold_out_result", 32'(bus.out_result), 32'd65025);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("idle_out_valid", 32'(bus.out_valid), 0);
        check("idle_in_ready", 32'(bus.in_ready), 1);

        // clken low for 4 cycles mid-vector; later beats flag signed, which must be ignored.
        e = '{res: 20'd98, cnt: 8'd3, ovf: 1'b0};
        sb.push_back(e);
        beat(8'd3, 8'd4, 1'b0, 1'b0);
        clken        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = 8'd5;
        bus.in_b     = 8'd6;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stall_in_ready", 32'(bus.in_ready), 0);
            @(negedge clk);
        end
        clken = 1'b1;
        beat(8'd5, 8'd6, 1'b0, 1'b1);
        beat(8'd7, 8'd8, 1'b1, 1'b1);
        wait_out(cyc);
        check("latency_stall", 32'(cyc), 2);
        @(negedge clk);

        // Mode fixed by first beat: unsigned 1*1 + 255*2 = 511 (signed would be -1).
        e = '{res: 20'd511, cnt: 8'd2, ovf: 1'b0};
        sb.push_back(e);
        beat(8'd1, 8'd1, 1'b0, 1'b0);
        beat(8'd255, 8'd2, 1'b1, 1'b1);

        // Count saturates at 255 after 300 beats; result 300.
        e = '{res: 20'd300, cnt: 8'd255, ovf: 1'b0};
        sb.push_back(e);
        for (int i = 0; i < 300; i++) beat(8'd1, 8'd1, (i == 299), 1'b0);

        // 20 * 65025 = 1300500: clamps or wraps depending on build.
`ifdef MAC_STREAM_SAT_EN
        e = '{res: 20'hFFFFF, cnt: 8'd20, ovf: 1'b1};
`else
        e = '{res: 20'd251924, cnt: 8'd20, ovf: 1'b0};
`endif
        sb.push_back(e);
        for (int i = 0; i < 20; i++) beat(8'd255, 8'd255, (i == 19), 1'b0);
        wait_out(cyc);
        @(negedge clk);

        // Reset during ACC after two beats: outputs clear at once, vector discarded.
        beat(8'd1, 8'd2, 1'b0, 1'b0);
        beat(8'd3, 8'd4, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 0);
        check("midrst_out_result", 32'(bus.out_result), 0);
        check("midrst_out_count", 32'(bus.out_count), 0);
        check("midrst_out_ovf", 32'(bus.out_ovf), 0);
        check("midrst_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        e = '{res: 20'd1, cnt: 8'd1, ovf: 1'b0};
        sb.push_back(e);
        beat(8'd1, 8'd1, 1'b1, 1'b0);

        // Drain the scoreboard.
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) timeout("scoreboard_drain");
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_stream.md
MAC_STREAM -- requirements
Module: mac_stream

Interface
REQ-001 SHALL have parameter A_W, default 8, operand A width in bits.
REQ-002 SHALL have parameter B_W, default 8, operand B width in bits.
REQ-003 SHALL have parameter ACC_W, default 24, accumulator/result width; ACC_W >= A_W+B_W.
REQ-004 SHALL have parameter CNT_W, default 8, beat-counter width.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port clken  input  1  global enable; low freezes all state.
REQ-008 SHALL have port in_valid  input  1  operand beat offered.
REQ-009 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-010 SHALL have port in_a  input  A_W  operand A.
REQ-011 SHALL have port in_b  input  B_W  operand B.
REQ-012 SHALL have port in_last  input  1  final beat of the current vector.
REQ-013 SHALL have port in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled on first beat.
REQ-014 SHALL have port out_valid  output  1  result held and offered.
REQ-015 SHALL have port out_ready  input  1  consumer accepts result.
REQ-016 SHALL have port out_result  output  ACC_W  dot-product result.
REQ-017 SHALL have port out_count  output  CNT_W  beats accumulated in the vector.
REQ-018 SHALL have port out_ovf  output  1  overflow occurred in the vector (see Configuration).

Function
REQ-019 SHALL implement states IDLE, ACC, DRAIN, OUT; transfers happen only when clken=1.
REQ-020 SHALL assert in_ready iff clken=1 and state is IDLE or ACC; beat accepted when in_valid & in_ready.
REQ-021 SHALL, on a beat accepted in IDLE, latch in_signed as vector mode, clear accumulator and count, and go to ACC (or DRAIN if in_last=1).
REQ-022 SHALL ignore in_signed on non-first beats; mode is fixed for the whole vector.
REQ-023 SHALL register operands in stage 1 and add the full-precision product (sign- or zero-extended to ACC_W) into the accumulator in stage 2.
REQ-024 SHALL sustain one beat per enabled cycle in ACC with no bubbles.
REQ-025 SHALL, on accepted beat with in_last=1, enter DRAIN for exactly 2 enabled cycles (in_ready=0), then enter OUT.
REQ-026 SHALL hold out_valid=1 and out_result/out_count/out_ovf stable in OUT until out_ready=1 with clken=1, then return to IDLE; out_valid=0 in all other states.
REQ-027 SHALL make out_valid rise 3 enabled cycles after the in_last beat is accepted.
REQ-028 SHALL increment out_count per accepted beat, saturating at 2^CNT_W-1.
REQ-029 SHALL hold state, pipeline, and outputs when clken=0; in_ready=0 while clken=0.
REQ-030 SHALL treat an in_valid with in_ready=0 as not accepted; upstream must hold data.

Reset
REQ-031 SHALL on reset=1 immediately force state IDLE, in_ready=0 until next clock, out_valid=0, out_result=0, out_count=0, out_ovf=0, pipeline cleared.
REQ-032 SHALL discard any partial vector or unconsumed result on reset mid-operation; first beat after release starts a new vector.

Configuration
REQ-033 SHALL with MAC_STREAM_SAT_EN defined clamp accumulator at the ACC_W range limit of the vector mode (signed: -2^(ACC_W-1)..2^(ACC_W-1)-1; unsigned: 0..2^ACC_W-1) and set sticky out_ovf on any clamp.
REQ-034 SHALL without MAC_STREAM_SAT_EN wrap modulo 2^ACC_W and tie out_ovf to 0.

Verification (A_W=B_W=8, ACC_W=20, CNT_W=8)
REQ-035 Unsigned vector (3,4),(5,6),(7,8) last, out_ready=1 -> out_result=98, out_count=3, out_valid 3 cycles after last beat.
REQ-036 Signed vector (-2,3),(4,-5) last -> out_result=0xFFFE6 (-26), out_count=2.
REQ-037 Single beat (255,255) unsigned, in_last=1, out_ready=0 for 5 cycles -> in_ready=0 and result 65025 held stable until out_ready=1, then IDLE.
REQ-038 clken=0 for 4 cycles mid-vector -> no beat taken, final result identical to unstalled run.
REQ-039 20 beats of (255,255) unsigned: SAT_EN -> out_result=0xFFFFF, out_ovf=1; no SAT_EN -> out_result=1300500 mod 2^20=251924, out_ovf=0.
REQ-040 reset pulse during ACC after 2 beats -> outputs zero at once; next vector (1,1) last yields out_result=1, out_count=1.
